// File: rtl/dmu_sii_chk_pkg.sv
// Shared definitions for the DMU->SII inbound checker: error codes, FSM states,
// default header tag position and the error-priority helper.
package dmu_sii_chk_pkg;

    localparam int DEF_TAG_LSB = 64;

    typedef enum logic [2:0] {
        ERR_NONE        = 3'd0,
        ERR_PARITY      = 3'd1,
        ERR_HDR_IN_DATA = 3'd2,
        ERR_BOTH_REQ    = 3'd3,
        ERR_TAG_REUSE   = 3'd4,
        ERR_SPUR_ACK    = 3'd5,
        ERR_BE_ZERO     = 3'd6
    } err_code_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_DATA = 1'b1
    } state_e;

    // Lowest set code wins; scanning downward leaves the smallest index last.
    function automatic logic [2:0] first_err(input logic [7:0] errs);
        logic [2:0] code;
        code = ERR_NONE;
        for (int i = 7; i >= 1; i--) begin
            if (errs[i]) code = 3'(i);
        end
        return code;
    endfunction

endpackage

// File: rtl/dmu_sii_par_chk.sv
// Per-lane even-parity checker: one parity bit covers each 16-bit lane, and a
// lane is in error when {lane, parity bit} has odd weight.
module dmu_sii_par_chk #(
    parameter int DATA_W = 128,
    parameter int PAR_W  = DATA_W / 16
) (
    input  logic [DATA_W-1:0] data,
    input  logic [PAR_W-1:0]  parity,
    output logic [PAR_W-1:0]  par_err
);

    for (genvar i = 0; i < PAR_W; i++) begin : g_lane
        assign par_err[i] = ^{data[16*i +: 16], parity[i]};
    end

endmodule

// File: rtl/dmu_sii_inbound_chk.sv
// Inbound DMU->SII checker: header/data framing, lane parity, write-tag ownership
// against SII write acks, and saturating per-type transaction counters.
module dmu_sii_inbound_chk
    import dmu_sii_chk_pkg::*;
#(
    parameter int DATA_W     = 128,
    parameter int PAR_W      = DATA_W / 16,
    parameter int BE_W       = DATA_W / 8,
    parameter int TAG_W      = 4,
    parameter int TAG_LSB    = DEF_TAG_LSB,
    parameter int DATA_BEATS = 4,
    parameter int CNT_W      = 32,
    parameter int NUM_TAGS   = 2 ** TAG_W
) (
    input  logic                iol2clk,
    input  logic                rst_l,
    input  logic                chk_en,
    input  logic                dmu_sii_hdr_vld,
    input  logic                dmu_sii_reqbypass,
    input  logic                dmu_sii_datareq,
    input  logic                dmu_sii_datareq16,
    input  logic [DATA_W-1:0]   dmu_sii_data,
    input  logic [PAR_W-1:0]    dmu_sii_parity,
    input  logic [BE_W-1:0]     dmu_sii_be,
    input  logic                sii_dmu_wrack_vld,
    input  logic [TAG_W-1:0]    sii_dmu_wrack_tag,
    output logic                chk_err_vld,
    output logic [2:0]          chk_err_code,
    output logic [7:0]          chk_err_sticky,
    output logic [NUM_TAGS-1:0] chk_tag_busy,
    output logic [TAG_W:0]      chk_outstanding,
    output logic [CNT_W-1:0]    chk_hdr_cnt,
    output logic [CNT_W-1:0]    chk_wr_cnt,
    output logic [CNT_W-1:0]    chk_rd_cnt,
    output logic [CNT_W-1:0]    chk_byp_cnt
);

    localparam int BL_W = (DATA_BEATS > 1) ? $clog2(DATA_BEATS) : 1;

    state_e                state_q, state_d;
    logic [BL_W-1:0]       beat_left_q, beat_left_d;
    logic                  is16_q, is16_d;
    logic [NUM_TAGS-1:0]   busy_q, busy_d;
    logic [TAG_W:0]        outstanding_q, outstanding_d;
    logic [CNT_W-1:0]      hdr_cnt_q, hdr_cnt_d;
    logic [CNT_W-1:0]      wr_cnt_q, wr_cnt_d;
    logic [CNT_W-1:0]      rd_cnt_q, rd_cnt_d;
    logic [CNT_W-1:0]      byp_cnt_q, byp_cnt_d;
    logic                  err_vld_q, err_vld_d;
    logic [2:0]            err_code_q, err_code_d;
    logic [7:0]            sticky_q, sticky_d;
    logic [7:0]            errs;

    logic [PAR_W-1:0]      par_err;
    logic                  hdr_take;
    logic                  in_data;
    logic                  set_tag;
    logic                  ack_hits_hdr;
    logic [TAG_W-1:0]      hdr_tag;

    dmu_sii_par_chk #(
        .DATA_W (DATA_W),
        .PAR_W  (PAR_W)
    ) u_par_chk (
        .data    (dmu_sii_data),
        .parity  (dmu_sii_parity),
        .par_err (par_err)
    );

    assign hdr_take     = chk_en && (state_q == ST_IDLE) && dmu_sii_hdr_vld;
    assign in_data      = chk_en && (state_q == ST_DATA);
    assign hdr_tag      = dmu_sii_data[TAG_LSB +: TAG_W];
    assign set_tag      = hdr_take && (dmu_sii_datareq || dmu_sii_datareq16);
    assign ack_hits_hdr = sii_dmu_wrack_vld && (sii_dmu_wrack_tag == hdr_tag);

    always_comb begin
        // NOTE: combinational logic uses blocking (=); only the always_ff below uses non-blocking (<=).
        // NOTE: every _d starts from its hold/idle value so no path leaves it unassigned (no latch).
        state_d     = state_q;
        beat_left_d = beat_left_q;
        is16_d      = is16_q;
        busy_d      = busy_q;
        hdr_cnt_d   = hdr_cnt_q;
        wr_cnt_d    = wr_cnt_q;
        rd_cnt_d    = rd_cnt_q;
        byp_cnt_d   = byp_cnt_q;
        sticky_d    = sticky_q;
        errs        = '0;

        errs[ERR_PARITY]      = (hdr_take || in_data) && (|par_err);
        errs[ERR_HDR_IN_DATA] = in_data && dmu_sii_hdr_vld;
        errs[ERR_BOTH_REQ]    = hdr_take && dmu_sii_datareq && dmu_sii_datareq16;
        errs[ERR_TAG_REUSE]   = set_tag && busy_q[hdr_tag] && !ack_hits_hdr;
        errs[ERR_SPUR_ACK]    = chk_en && sii_dmu_wrack_vld && !busy_q[sii_dmu_wrack_tag]
                                && !(set_tag && ack_hits_hdr);
        errs[ERR_BE_ZERO]     = in_data && is16_q && (dmu_sii_be == '0);

        // Clear before set: a same-tag ack retires the old owner, the header claims it anew.
        if (sii_dmu_wrack_vld) busy_d[sii_dmu_wrack_tag] = 1'b0;
        if (set_tag)           busy_d[hdr_tag]           = 1'b1;

        if (hdr_take) begin
            if (hdr_cnt_q != '1) hdr_cnt_d = hdr_cnt_q + CNT_W'(1);
            if (dmu_sii_reqbypass && byp_cnt_q != '1) byp_cnt_d = byp_cnt_q + CNT_W'(1);
            if (dmu_sii_datareq || dmu_sii_datareq16) begin
                if (wr_cnt_q != '1) wr_cnt_d = wr_cnt_q + CNT_W'(1);
            end else begin
                if (rd_cnt_q != '1) rd_cnt_d = rd_cnt_q + CNT_W'(1);
            end
            if (dmu_sii_datareq) begin
                state_d     = ST_DATA;
                beat_left_d = BL_W'(DATA_BEATS - 1);
                is16_d      = 1'b0;
            end else if (dmu_sii_datareq16) begin
                state_d     = ST_DATA;
                beat_left_d = '0;
                is16_d      = 1'b1;
            end
        end else if (in_data) begin
            if (beat_left_q == '0) state_d = ST_IDLE;
            else                   beat_left_d = beat_left_q - BL_W'(1);
        end

        err_vld_d  = |errs;
        err_code_d = first_err(errs);
        if (err_vld_d) sticky_d[err_code_d] = 1'b1;

        outstanding_d = '0;
        for (int i = 0; i < NUM_TAGS; i++) begin
            outstanding_d = outstanding_d + {{TAG_W{1'b0}}, busy_d[i]};
        end
    end

    always_ff @(posedge iol2clk or negedge rst_l) begin
        if (!rst_l) begin
            state_q       <= ST_IDLE;
            beat_left_q   <= '0;
            is16_q        <= 1'b0;
            // NOTE: the busy vector is control state, not a storage array, so it must be reset.
            busy_q        <= '0;
            outstanding_q <= '0;
            hdr_cnt_q     <= '0;
            wr_cnt_q      <= '0;
            rd_cnt_q      <= '0;
            byp_cnt_q     <= '0;
            err_vld_q     <= 1'b0;
            err_code_q    <= '0;
            sticky_q      <= '0;
        end else begin
            state_q       <= state_d;
            beat_left_q   <= beat_left_d;
            is16_q        <= is16_d;
            busy_q        <= busy_d;
            outstanding_q <= outstanding_d;
            hdr_cnt_q     <= hdr_cnt_d;
            wr_cnt_q      <= wr_cnt_d;
            rd_cnt_q      <= rd_cnt_d;
            byp_cnt_q     <= byp_cnt_d;
            err_vld_q     <= err_vld_d;
            err_code_q    <= err_code_d;
            sticky_q      <= sticky_d;
        end
    end

    assign chk_err_vld     = err_vld_q;
    assign chk_err_code    = err_code_q;
    assign chk_err_sticky  = sticky_q;
    assign chk_tag_busy    = busy_q;
    assign chk_outstanding = outstanding_q;
    assign chk_hdr_cnt     = hdr_cnt_q;
    assign chk_wr_cnt      = wr_cnt_q;
    assign chk_rd_cnt      = rd_cnt_q;
    assign chk_byp_cnt     = byp_cnt_q;

endmodule

// File: tb/tb_dmu_sii_inbound_chk.sv
// Bench for dmu_sii_inbound_chk: directed scenarios with literal expectations, then
// random traffic, all compared every cycle against a transaction-level model.
module tb_dmu_sii_inbound_chk;

    localparam int DATA_W     = 128;
    localparam int PAR_W      = DATA_W / 16;
    localparam int BE_W       = DATA_W / 8;
    localparam int TAG_W      = 4;
    localparam int TAG_LSB    = 64;
    localparam int DATA_BEATS = 4;
    localparam int CNT_W      = 32;
    localparam int NUM_TAGS   = 2 ** TAG_W;

    logic                iol2clk = 1'b0;
    logic                rst_l   = 1'b0;
    logic                chk_en  = 1'b1;
    logic                dmu_sii_hdr_vld   = 1'b0;
    logic                dmu_sii_reqbypass = 1'b0;
    logic                dmu_sii_datareq   = 1'b0;
    logic                dmu_sii_datareq16 = 1'b0;
    logic [DATA_W-1:0]   dmu_sii_data      = '0;
    logic [PAR_W-1:0]    dmu_sii_parity    = '0;
    logic [BE_W-1:0]     dmu_sii_be        = '0;
    logic                sii_dmu_wrack_vld = 1'b0;
    logic [TAG_W-1:0]    sii_dmu_wrack_tag = '0;

    logic                chk_err_vld;
    logic [2:0]          chk_err_code;
    logic [7:0]          chk_err_sticky;
    logic [NUM_TAGS-1:0] chk_tag_busy;
    logic [TAG_W:0]      chk_outstanding;
    logic [CNT_W-1:0]    chk_hdr_cnt, chk_wr_cnt, chk_rd_cnt, chk_byp_cnt;

    int n_checks = 0;
    int n_errs   = 0;

    dmu_sii_inbound_chk #(
        .DATA_W(DATA_W), .PAR_W(PAR_W), .BE_W(BE_W), .TAG_W(TAG_W),
        .TAG_LSB(TAG_LSB), .DATA_BEATS(DATA_BEATS), .CNT_W(CNT_W)
    ) dut (
        .iol2clk           (iol2clk),
        .rst_l             (rst_l),
        .chk_en            (chk_en),
        .dmu_sii_hdr_vld   (dmu_sii_hdr_vld),
        .dmu_sii_reqbypass (dmu_sii_reqbypass),
        .dmu_sii_datareq   (dmu_sii_datareq),
        .dmu_sii_datareq16 (dmu_sii_datareq16),
        .dmu_sii_data      (dmu_sii_data),
        .dmu_sii_parity    (dmu_sii_parity),
        .dmu_sii_be        (dmu_sii_be),
        .sii_dmu_wrack_vld (sii_dmu_wrack_vld),
        .sii_dmu_wrack_tag (sii_dmu_wrack_tag),
        .chk_err_vld       (chk_err_vld),
        .chk_err_code      (chk_err_code),
        .chk_err_sticky    (chk_err_sticky),
        .chk_tag_busy      (chk_tag_busy),
        .chk_outstanding   (chk_outstanding),
        .chk_hdr_cnt       (chk_hdr_cnt),
        .chk_wr_cnt        (chk_wr_cnt),
        .chk_rd_cnt        (chk_rd_cnt),
        .chk_byp_cnt       (chk_byp_cnt)
    );

    always #5 iol2clk = ~iol2clk;

    // ---------------- reference model (transaction level) ----------------
    int                  m_beats = 0;      // data beats still owed by the current burst
    bit                  m_is16  = 1'b0;
    bit [NUM_TAGS-1:0]   m_busy  = '0;
    longint              m_hdr = 0, m_wr = 0, m_rd = 0, m_byp = 0;
    bit                  m_err_vld = 1'b0;
    int                  m_err_code = 0;
    bit [7:0]            m_sticky = '0;

    localparam longint CNT_MAX = (64'd1 << CNT_W) - 1;

    function automatic longint sat_inc(input longint v);
        return (v >= CNT_MAX) ? v : v + 1;
    endfunction

    function automatic bit parity_bad(input logic [DATA_W-1:0] d, input logic [PAR_W-1:0] p);
        bit bad;
        bad = 1'b0;
        for (int i = 0; i < PAR_W; i++) begin
            if (($countones(d[16*i +: 16]) + int'(p[i])) % 2 == 1) bad = 1'b1;
        end
        return bad;
    endfunction

    task automatic model_reset();
        m_beats = 0; m_is16 = 1'b0; m_busy = '0;
        m_hdr = 0; m_wr = 0; m_rd = 0; m_byp = 0;
        m_err_vld = 1'b0; m_err_code = 0; m_sticky = '0;
    endtask

    task automatic model_step();
        bit [7:0] e;
        bit       in_burst, take, wr;
        int       tag, code;
        e        = '0;
        in_burst = (m_beats > 0);
        take     = chk_en && !in_burst && dmu_sii_hdr_vld;
        wr       = take && (dmu_sii_datareq || dmu_sii_datareq16);
        tag      = int'(dmu_sii_data[TAG_LSB +: TAG_W]);

        if (chk_en && (in_burst || take) && parity_bad(dmu_sii_data, dmu_sii_parity)) e[1] = 1'b1;
        if (chk_en && in_burst && dmu_sii_hdr_vld) e[2] = 1'b1;
        if (take && dmu_sii_datareq && dmu_sii_datareq16) e[3] = 1'b1;
        if (wr && m_busy[tag] && !(sii_dmu_wrack_vld && int'(sii_dmu_wrack_tag) == tag)) e[4] = 1'b1;
        if (chk_en && sii_dmu_wrack_vld && !m_busy[sii_dmu_wrack_tag]
            && !(wr && int'(sii_dmu_wrack_tag) == tag)) e[5] = 1'b1;
        if (chk_en && in_burst && m_is16 && dmu_sii_be == '0) e[6] = 1'b1;

        if (sii_dmu_wrack_vld) m_busy[sii_dmu_wrack_tag] = 1'b0;
        if (wr) m_busy[tag] = 1'b1;

        if (chk_en) begin
            if (in_burst) begin
                m_beats = m_beats - 1;
            end else if (take) begin
                m_hdr = sat_inc(m_hdr);
                if (dmu_sii_reqbypass) m_byp = sat_inc(m_byp);
                if (wr) m_wr = sat_inc(m_wr);
                else    m_rd = sat_inc(m_rd);
                if (dmu_sii_datareq) begin
                    m_beats = DATA_BEATS; m_is16 = 1'b0;
                end else if (dmu_sii_datareq16) begin
                    m_beats = 1; m_is16 = 1'b1;
                end
            end
        end

        code = 0;
        for (int i = 6; i >= 1; i--) if (e[i]) code = i;
        m_err_vld  = (e != 0);
        m_err_code = code;
        if (m_err_vld) m_sticky[code] = 1'b1;
    endtask

    initial begin
        forever begin
            @(posedge iol2clk or negedge rst_l);
            if (!rst_l) model_reset();
            else        model_step();
        end
    end

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    initial begin
        forever begin
            @(negedge iol2clk);
            check("err_vld",     64'(chk_err_vld),     64'(m_err_vld));
            check("err_code",    64'(chk_err_code),    64'(m_err_code));
            check("err_sticky",  64'(chk_err_sticky),  64'(m_sticky));
            check("tag_busy",    64'(chk_tag_busy),    64'(m_busy));
            check("outstanding", 64'(chk_outstanding), 64'($countones(m_busy)));
            check("hdr_cnt",     64'(chk_hdr_cnt),     64'(m_hdr));
            check("wr_cnt",      64'(chk_wr_cnt),      64'(m_wr));
            check("rd_cnt",      64'(chk_rd_cnt),      64'(m_rd));
            check("byp_cnt",     64'(chk_byp_cnt),     64'(m_byp));
        end
    end

    // ---------------- stimulus helpers ----------------
    function automatic logic [DATA_W-1:0] rand_word(input int tag);
        logic [DATA_W-1:0] d;
        d = {$urandom, $urandom, $urandom, $urandom};
        d[TAG_LSB +: TAG_W] = TAG_W'(tag);
        return d;
    endfunction

    function automatic logic [PAR_W-1:0] good_par(input logic [DATA_W-1:0] d);
        logic [PAR_W-1:0] p;
        for (int i = 0; i < PAR_W; i++) p[i] = ^d[16*i +: 16];
        return p;
    endfunction

    // Drive one cycle of inputs, then return at the next falling edge with outputs settled.
    task automatic cyc(input bit hv, input bit byp, input bit dr, input bit dr16, input int tag,
                       input int flip_lane, input logic [BE_W-1:0] be,
                       input bit av, input int atag);
        logic [DATA_W-1:0] d;
        logic [PAR_W-1:0]  p;
        d = rand_word(tag);
        p = good_par(d);
        if (flip_lane >= 0) p[flip_lane] = ~p[flip_lane];
        dmu_sii_hdr_vld   = hv;
        dmu_sii_reqbypass = byp;
        dmu_sii_datareq   = dr;
        dmu_sii_datareq16 = dr16;
        dmu_sii_data      = d;
        dmu_sii_parity    = p;
        dmu_sii_be        = be;
        sii_dmu_wrack_vld = av;
        sii_dmu_wrack_tag = TAG_W'(atag);
        @(negedge iol2clk);
    endtask

    task automatic beat();
        cyc(0, 0, 0, 0, 0, -1, '1, 0, 0);
    endtask

    task automatic ack(input int t);
        cyc(0, 0, 0, 0, 0, -1, '1, 1, t);
    endtask

    task automatic idle_inputs();
        dmu_sii_hdr_vld = 0; dmu_sii_reqbypass = 0; dmu_sii_datareq = 0; dmu_sii_datareq16 = 0;
        dmu_sii_data = '0; dmu_sii_parity = '0; dmu_sii_be = '0;
        sii_dmu_wrack_vld = 0; sii_dmu_wrack_tag = '0;
    endtask

    initial begin
        repeat (3) @(negedge iol2clk);
        rst_l = 1'b1;
        @(negedge iol2clk);
        check("rst_err_vld", 64'(chk_err_vld), 64'd0);
        check("rst_hdr_cnt", 64'(chk_hdr_cnt), 64'd0);
        check("rst_busy",    64'(chk_tag_busy), 64'd0);

        // Write tag 3, four clean beats, then ack.
        cyc(1, 0, 1, 0, 3, -1, '1, 0, 0);
        check("wr3_busy3", 64'(chk_tag_busy[3]), 64'd1);
        check("wr3_outst", 64'(chk_outstanding), 64'd1);
        check("wr3_wrcnt", 64'(chk_wr_cnt), 64'd1);
        repeat (DATA_BEATS) beat();
        ack(3);
        check("ack3_busy",  64'(chk_tag_busy), 64'd0);
        check("ack3_outst", 64'(chk_outstanding), 64'd0);
        check("ack3_stky",  64'(chk_err_sticky), 64'd0);

        // Bypass read, then a header on the very next cycle is still accepted.
        cyc(1, 1, 0, 0, 0, -1, '1, 0, 0);
        check("rd_rdcnt",  64'(chk_rd_cnt), 64'd1);
        check("rd_bypcnt", 64'(chk_byp_cnt), 64'd1);

        // Parity lane 5 flipped on data beat 2.
        cyc(1, 0, 1, 0, 2, -1, '1, 0, 0);
        check("par_hdrcnt", 64'(chk_hdr_cnt), 64'd3);
        beat();
        cyc(0, 0, 0, 0, 0, 5, '1, 0, 0);
        check("par_vld",  64'(chk_err_vld), 64'd1);
        check("par_code", 64'(chk_err_code), 64'd1);
        check("par_stky", 64'(chk_err_sticky), 64'h02);
        beat(); beat();
        ack(2);

        // Header on beat 1 of a burst: flagged, ignored, beat consumed.
        cyc(1, 0, 1, 0, 4, -1, '1, 0, 0);
        cyc(1, 0, 1, 0, 5, -1, '1, 0, 0);
        check("hid_code",   64'(chk_err_code), 64'd2);
        check("hid_hdrcnt", 64'(chk_hdr_cnt), 64'd4);
        check("hid_busy5",  64'(chk_tag_busy[5]), 64'd0);
        beat(); beat(); beat();
        cyc(1, 0, 0, 0, 0, -1, '1, 0, 0);
        check("hid_next_hdr", 64'(chk_hdr_cnt), 64'd5);
        ack(4);

        // Tag 7 reuse, then reuse covered by a same-cycle ack.
        cyc(1, 0, 0, 1, 7, -1, '1, 0, 0);
        beat();
        cyc(1, 0, 0, 1, 7, -1, '1, 0, 0);
        check("reuse_code", 64'(chk_err_code), 64'd4);
        beat();
        cyc(1, 0, 0, 1, 7, -1, '1, 1, 7);
        check("reack_vld",   64'(chk_err_vld), 64'd0);
        check("reack_busy7", 64'(chk_tag_busy[7]), 64'd1);
        beat();

        // Spurious ack to an idle tag.
        ack(9);
        check("spur_code", 64'(chk_err_code), 64'd5);
        check("spur_stky", 64'(chk_err_sticky), 64'h36);

        // Reset in the middle of a burst.
        cyc(1, 0, 1, 0, 1, -1, '1, 0, 0);
        beat();
        idle_inputs();
        rst_l = 1'b0;
        #2;
        check("mrst_hdr",   64'(chk_hdr_cnt), 64'd0);
        check("mrst_busy",  64'(chk_tag_busy), 64'd0);
        check("mrst_stky",  64'(chk_err_sticky), 64'd0);
        check("mrst_outst", 64'(chk_outstanding), 64'd0);
        repeat (2) @(negedge iol2clk);
        rst_l = 1'b1;
        cyc(1, 0, 0, 0, 0, -1, '1, 0, 0);
        check("post_rst_hdr", 64'(chk_hdr_cnt), 64'd1);
        check("post_rst_rd",  64'(chk_rd_cnt), 64'd1);

        // Random traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            bit hv, dr, dr16, av;
            int kind, flip;
            logic [BE_W-1:0] be;
            chk_en = ($urandom_range(0, 9) != 0);
            hv   = (m_beats > 0) ? ($urandom_range(0, 19) == 0) : ($urandom_range(0, 2) == 0);
            kind = $urandom_range(0, 9);
            dr   = (kind <= 3) || (kind == 7);
            dr16 = (kind >= 4 && kind <= 7);
            flip = ($urandom_range(0, 29) == 0) ? $urandom_range(0, PAR_W - 1) : -1;
            be   = ($urandom_range(0, 5) == 0) ? '0 : BE_W'($urandom);
            av   = ($urandom_range(0, 3) == 0);
            cyc(hv, 1'($urandom), dr, dr16, $urandom_range(0, 7), flip, be, av, $urandom_range(0, 7));
        end
        chk_en = 1'b1;
        idle_inputs();
        repeat (2) @(negedge iol2clk);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule

// File: doc/dmu_sii_inbound_chk.md
# dmu_sii_inbound_chk

Parametrised inbound-path checker on the DMU→SII interface, clocked by the SII I/O L2 clock. It supersedes the header-print-only monitor. It tracks header/data framing, per-beat parity, write-tag ownership against SII write acks, and per-type transaction counts. It drives registered error and statistics outputs that the bench scoreboard and end-of-test report sample.

## Interface
- DATA_W, 128, data bus width; multiple of 16
- PAR_W, DATA_W/16, one even-parity bit per 16-bit lane
- BE_W, DATA_W/8, byte-enable width
- TAG_W, 4, write-ack tag width; NUM_TAGS = 2**TAG_W
- TAG_LSB, 64, bit position of the tag field in the header word
- DATA_BEATS, 4, data beats following a datareq header
- CNT_W, 32, statistics counter width (saturating)

Ports:
- iol2clk  in  1  clock
- rst_l  in  1  asynchronous active-low reset
- chk_en  in  1  checker enable; when 0, no state updates except tag clears from acks
- dmu_sii_hdr_vld  in  1  header valid; header sits on dmu_sii_data
- dmu_sii_reqbypass  in  1  bypass-queue request qualifier (header cycle)
- dmu_sii_datareq  in  1  write with DATA_BEATS beats (header cycle)
- dmu_sii_datareq16  in  1  write with one 16B beat (header cycle)
- dmu_sii_data  in  DATA_W  header/data word
- dmu_sii_parity  in  PAR_W  lane parity
- dmu_sii_be  in  BE_W  byte enables (data beats)
- sii_dmu_wrack_vld  in  1  write ack valid
- sii_dmu_wrack_tag  in  TAG_W  acked tag
- chk_err_vld  out  1  one-cycle error pulse
- chk_err_code  out  3  code of highest-priority error that cycle
- chk_err_sticky  out  8  sticky OR of 1<<code, cleared only by reset
- chk_tag_busy  out  NUM_TAGS  outstanding write tags
- chk_outstanding  out  TAG_W+1  popcount of chk_tag_busy
- chk_hdr_cnt, chk_wr_cnt, chk_rd_cnt, chk_byp_cnt  out  CNT_W each  statistics

## Operation
- FSM: IDLE, DATA. IDLE + hdr_vld + chk_en: accept header. If datareq → DATA with beat_left=DATA_BEATS-1. If datareq16 → DATA with beat_left=0. Otherwise it is a read and stays in IDLE. DATA: each cycle is one data beat. At beat_left==0, return to IDLE, else decrement.
- Counters on each accepted header: hdr_cnt always; wr_cnt if datareq|datareq16; rd_cnt otherwise; byp_cnt if reqbypass. All counters saturate at all-ones.
- Tag: a write header sets busy[data[TAG_LSB+:TAG_W]]. A wrack clears busy[wrack_tag].
- Error codes (priority: lowest code wins):
  - 1 PARITY: any lane on a header or data beat has odd parity over {data lane, parity bit}.
  - 2 HDR_IN_DATA: hdr_vld while in DATA. The header is ignored and the beat is still consumed.
  - 3 BOTH_REQ: datareq and datareq16 both set. Treated as a datareq.
  - 4 TAG_REUSE: write header whose tag is busy and not simultaneously acked.
  - 5 SPUR_ACK: wrack to a non-busy tag that is not being set the same cycle.
  - 6 BE_ZERO: datareq16 beat with be==0.
- Simultaneous wrack and write header on the same tag: the ack clears the old owner, the header sets the new one. Busy stays 1 and no error is raised.
- While chk_en=0: FSM, counters, and errors freeze. Wracks still clear tags and never flag.

## Timing
- All outputs are registered. Error pulse, counters, and busy update one cycle after the sampled input edge.
- Reset (async assert, sync deassert by the environment): FSM=IDLE, beat_left=0, all counters=0, busy=0, outstanding=0, err_vld=0, err_code=0, sticky=0.
- Reset mid-burst abandons the burst. The first post-reset cycle is treated as IDLE.
- Back-to-back headers allowed: a header is legal on the cycle after the last data beat.

## Structure
- Package dmu_sii_chk_pkg holds the error-code constants, the FSM state enum, and the default TAG_LSB.
- Sub-module dmu_sii_par_chk: combinational per-lane even-parity checker, parametrised on DATA_W. Outputs a PAR_W error vector.

## Test plan
- Write header, tag 3, datareq, 4 clean beats, then wrack tag 3 → wr_cnt=1, busy[3] rises then falls, outstanding 1→0, no error.
- Read header with reqbypass → rd_cnt=1, byp_cnt=1, FSM stays IDLE.
- Data beat 2 with parity lane 5 flipped → err_vld pulse, code=1, sticky=8'h02.
- Header during beat 1 of a burst → code=2. The burst still ends after 4 beats, and hdr_cnt is unchanged.
- Write header tag 7 while busy[7]=1 → code 4. Then the same header with a simultaneous wrack tag 7 → no error, busy[7]=1.
- wrack tag 9 with busy=0 → code 5. Assert rst_l low mid-burst → all outputs 0 and the next header is accepted.
